// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// field widths and the general-call address.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam logic I2C_RW_READ = 1'b1;
    localparam logic [I2C_ADDR_W-1:0] I2C_GENCALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus a FILTER_LEN-sample agreement filter for one
// I2C line; emits the accepted level and one-cycle rise/fall pulses.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // The newest synchronized sample plus FILTER_LEN-1 older ones must agree,
    // giving a latency of 2+FILTER_LEN cycles. FILTER_LEN must be at least 2.
    localparam int HW = FILTER_LEN - 1;

    logic          sync1_q, sync2_q;
    logic [HW-1:0] hist_q;
    logic [HW:0]   hist_d;
    logic          level_q, rise_q, fall_q;
    logic          all_hi, all_lo;

    assign hist_d = {hist_q, sync2_q};
    assign all_hi = sync2_q & (&hist_q);
    assign all_lo = ~sync2_q & ~(|hist_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            hist_q  <= hist_d[HW-1:0];
            rise_q  <= all_hi & ~level_q;
            fall_q  <= all_lo & level_q;
            if (all_hi) begin
                level_q <= 1'b1;
            end else if (all_lo) begin
                level_q <= 1'b0;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: receives bytes written to ADDR and returns tx_data on reads.
// Define I2C_TARGET_GENCALL_EN to also accept general-call (0x00) writes.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h2F,
    parameter int FILTER_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_out,
    output logic                  sda_enable,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_first,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  busy,
    output logic                  nack_det
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .raw_i(scl_in),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .raw_i(sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e            state_q;
    logic [2:0]            bit_cnt_q;
    logic [I2C_BYTE_W-1:0] shift_q;
    logic                  rw_q, phase_q, first_q;
    logic [1:0]            tx_pipe_q;
    logic                  sda_en_q, rx_valid_q, rx_first_q, tx_req_q, busy_q, nack_q;
    logic [I2C_BYTE_W-1:0] rx_data_q;

    logic                  start_cond, stop_cond, match_d;
    logic [I2C_BYTE_W-1:0] byte_d;

    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;
    assign byte_d     = {shift_q[I2C_BYTE_W-2:0], sda_lvl};

`ifdef I2C_TARGET_GENCALL_EN
    assign match_d = (byte_d[7:1] == ADDR) ||
                     ((byte_d[7:1] == I2C_GENCALL_ADDR) && (byte_d[0] != I2C_RW_READ));
`else
    assign match_d = (byte_d[7:1] == ADDR);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            first_q    <= 1'b0;
            tx_pipe_q  <= '0;
            sda_en_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            nack_q     <= 1'b0;
            // Read data is captured two cycles after the request pulse.
            tx_pipe_q  <= {tx_pipe_q[0], tx_req_q};
            if (tx_pipe_q[1]) begin
                shift_q <= tx_data;
            end

            if (start_cond) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= '0;
                sda_en_q  <= 1'b0;
                busy_q    <= 1'b0;
                phase_q   <= 1'b0;
                first_q   <= 1'b1;
                tx_pipe_q <= '0;
            end else if (stop_cond) begin
                state_q   <= ST_IDLE;
                sda_en_q  <= 1'b0;
                busy_q    <= 1'b0;
                phase_q   <= 1'b0;
                tx_pipe_q <= '0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= byte_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rw_q    <= byte_d[0];
                                phase_q <= 1'b0;
                                if (match_d) begin
                                    state_q <= ST_ADDR_ACK;
                                    busy_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK drive, second one ends it.
                    ST_ADDR_ACK, ST_WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                phase_q  <= 1'b1;
                                sda_en_q <= 1'b1;
                                if (rw_q == I2C_RW_READ) begin
                                    tx_req_q <= 1'b1;
                                end
                            end else begin
                                phase_q <= 1'b0;
                                if (rw_q == I2C_RW_READ) begin
                                    state_q  <= ST_READ;
                                    sda_en_q <= ~shift_q[7];
                                end else begin
                                    state_q  <= ST_WRITE;
                                    sda_en_q <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (scl_rise) begin
                            shift_q   <= byte_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= byte_d;
                                rx_valid_q <= 1'b1;
                                rx_first_q <= first_q;
                                first_q    <= 1'b0;
                                phase_q    <= 1'b0;
                                state_q    <= ST_WRITE_ACK;
                            end
                        end
                    end
                    // The MSB is already on the bus; each falling edge presents the next bit.
                    ST_READ: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 3'd0) begin
                                sda_en_q <= 1'b0;
                                phase_q  <= 1'b0;
                                state_q  <= ST_READ_ACK;
                            end else begin
                                shift_q  <= shift_q << 1;
                                sda_en_q <= ~shift_q[6];
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl) begin
                                nack_q  <= 1'b1;
                                state_q <= ST_IGNORE;
                            end else begin
                                tx_req_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q  <= 1'b0;
                            state_q  <= ST_READ;
                            sda_en_q <= ~shift_q[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_out    = 1'b0;
    assign sda_enable = sda_en_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_first   = rx_first_q;
    assign tx_req     = tx_req_q;
    assign busy       = busy_q;
    assign nack_det   = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller at 100 kHz on a
// 16 MHz clock, with an open-drain SDA model and event monitors.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 40;  // quarter SCL period in clk cycles

`ifdef I2C_TARGET_GENCALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;
  logic       sda_out, sda_enable, rx_valid, rx_first, tx_req, busy, nack_det;
  logic [7:0] rx_data, tx_data;
  logic [7:0] tx_reg = 8'h00;

  // Wired-AND: the target can only pull low, and only to the sda_out level.
  assign sda_line = sda_drv & (sda_enable ? sda_out : 1'b1);
  assign tx_data  = tx_reg;

  i2c_target #(.ADDR(7'h2F), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_drv), .sda_in(sda_line),
    .sda_out(sda_out), .sda_enable(sda_enable),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .nack_det(nack_det)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_mis = 0;
  int txr_cnt = 0, nack_cnt = 0, en_on_cnt = 0, en_viol = 0;
  logic [7:0] exp_q[$];
  logic       exp_first_q[$];
  logic [7:0] got_q[$];
  logic       got_first_q[$];
  logic [7:0] tx_q[$];
  logic       en_prev = 1'b0;
  logic       rst_prev = 1'b1;

  always @(posedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      got_first_q.push_back(rx_first);
    end
    if (tx_req) begin
      txr_cnt++;
      tx_reg <= (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
    end
    if (nack_det) nack_cnt++;
    if (sda_enable && !en_prev) en_on_cnt++;
    if ((sda_enable != en_prev) && scl_drv && !rst_prev) en_viol++;
    en_prev  <= sda_enable;
    rst_prev <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      chk({tag, "_first"}, 32'(got_first_q.pop_front()), 32'(exp_first_q.pop_front()));
    end
    exp_q.delete(); exp_first_q.delete(); got_q.delete(); got_first_q.delete();
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl_drv) begin
      sda_drv = 1'b1; tick(Q); scl_drv = 1'b1; tick(Q);
    end
    sda_drv = 1'b0; tick(2 * Q); scl_drv = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; tick(Q); scl_drv = 1'b1; tick(Q); sda_drv = 1'b1; tick(2 * Q);
  endtask

  task automatic clock_bit(input logic b, input bit glitch, output logic s);
    sda_drv = b; tick(Q);
    scl_drv = 1'b1; tick(Q / 2);
    s = sda_line;
    if (glitch) begin
      sda_drv = ~b; tick(1); sda_drv = b;
    end
    tick(Q / 2);
    scl_drv = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], (i == glitch_bit), s);
    clock_bit(1'b1, 1'b0, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clock_bit(~ack, 1'b0, s);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       s;
    int         t0, n0, e0;

    // reset state
    tick(5); rst = 1'b0; tick(2);
    chk("rst_sda_enable", 32'(sda_enable), 32'd0);
    chk("rst_sda_out", 32'(sda_out), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_first", 32'(rx_first), 32'd0);
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nack_det", 32'(nack_det), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // single-byte write of 0x32 to 0x2F
    bus_start();
    write_byte(8'h5E, -1, ack); chk("w1_addr_ack", 32'(ack), 32'd1);
    chk("w1_busy_addr", 32'(busy), 32'd1);
    exp_q.push_back(8'h32); exp_first_q.push_back(1'b1);
    write_byte(8'h32, -1, ack); chk("w1_data_ack", 32'(ack), 32'd1);
    chk("w1_busy_data", 32'(busy), 32'd1);
    bus_stop();
    chk("w1_busy_stop", 32'(busy), 32'd0);
    check_rx("w1_rx");

    // two-byte write
    bus_start();
    write_byte(8'h5E, -1, ack); chk("w2_addr_ack", 32'(ack), 32'd1);
    exp_q.push_back(8'h01); exp_first_q.push_back(1'b1);
    exp_q.push_back(8'h64); exp_first_q.push_back(1'b0);
    write_byte(8'h01, -1, ack); chk("w2_d0_ack", 32'(ack), 32'd1);
    write_byte(8'h64, -1, ack); chk("w2_d1_ack", 32'(ack), 32'd1);
    bus_stop();
    chk("w2_busy_stop", 32'(busy), 32'd0);
    chk("w2_state_stop", 32'(dut.state_q), 32'(ST_IDLE));
    check_rx("w2_rx");

    // address mismatch (0x2E)
    bus_start();
    write_byte(8'h5C, -1, ack); chk("mm_addr_nack", 32'(ack), 32'd0);
    chk("mm_busy", 32'(busy), 32'd0);
    write_byte(8'h11, -1, ack); chk("mm_data_nack", 32'(ack), 32'd0);
    bus_stop();
    check_rx("mm_rx");

    // read two bytes, ACK then NACK
    tx_q.push_back(8'hA5); tx_q.push_back(8'h3C);
    t0 = txr_cnt; n0 = nack_cnt;
    bus_start();
    write_byte(8'h5F, -1, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
    chk("rd_busy", 32'(busy), 32'd1);
    read_byte(1'b1, d); chk("rd_byte0", 32'(d), 32'hA5);
    read_byte(1'b0, d); chk("rd_byte1", 32'(d), 32'h3C);
    tick(8);
    chk("rd_tx_req_cnt", 32'(txr_cnt - t0), 32'd2);
    chk("rd_nack_cnt", 32'(nack_cnt - n0), 32'd1);
    chk("rd_released", 32'(sda_enable), 32'd0);
    chk("rd_state_ignore", 32'(dut.state_q), 32'(ST_IGNORE));
    bus_stop();
    chk("rd_busy_stop", 32'(busy), 32'd0);

    // glitches: 1-cycle SDA low while idle, 1-cycle SDA high mid-bit
    sda_drv = 1'b0; tick(1); sda_drv = 1'b1; tick(20);
    chk("gl_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    bus_start();
    write_byte(8'h5E, -1, ack); chk("gl_addr_ack", 32'(ack), 32'd1);
    exp_q.push_back(8'h5A); exp_first_q.push_back(1'b1);
    write_byte(8'h5A, 5, ack); chk("gl_data_ack", 32'(ack), 32'd1);
    chk("gl_busy", 32'(busy), 32'd1);
    check_rx("gl_rx");

    // repeated START after the 4th data bit of a write
    for (int i = 0; i < 4; i++) clock_bit(1'b1, 1'b0, s);
    bus_start();
    chk("rs_state_addr", 32'(dut.state_q), 32'(ST_ADDR));
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_no_rx", 32'(got_q.size()), 32'd0);
    write_byte(8'h5E, -1, ack); chk("rs_addr_ack", 32'(ack), 32'd1);
    exp_q.push_back(8'h7F); exp_first_q.push_back(1'b1);
    write_byte(8'h7F, -1, ack); chk("rs_data_ack", 32'(ack), 32'd1);
    bus_stop();
    check_rx("rs_rx");

    // reset while the target drives a 0 read bit
    tx_q.push_back(8'h3C);
    bus_start();
    write_byte(8'h5F, -1, ack); chk("rr_addr_ack", 32'(ack), 32'd1);
    tick(Q);
    chk("rr_driving0", 32'(sda_enable), 32'd1);
    scl_drv = 1'b1; tick(Q / 2);
    rst = 1'b1; tick(1);
    chk("rr_released", 32'(sda_enable), 32'd0);
    rst = 1'b0;
    tick(Q / 2); scl_drv = 1'b0; tick(Q);
    e0 = en_on_cnt;
    write_byte(8'hA6, -1, ack);
    clock_bit(1'b0, 1'b0, s);
    chk("rr_no_drive", 32'(en_on_cnt - e0), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    bus_stop();
    check_rx("rr_rx");

    // general-call address 0x00, write
    bus_start();
    write_byte(8'h00, -1, ack); chk("gc_addr_ack", 32'(ack), 32'(GC));
    if (GC) begin
      exp_q.push_back(8'h99); exp_first_q.push_back(1'b1);
    end
    write_byte(8'h99, -1, ack); chk("gc_data_ack", 32'(ack), 32'(GC));
    bus_stop();
    check_rx("gc_rx");

    chk("sda_en_timing", 32'(en_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
